sr_latch_checker: RTL and testbench

Synchronous checker for the NOR SR latch interface. It watches the latch inputs (s, r) and outputs (q, q_bar) and keeps its own model of the expected latch state. After each input change it waits a settling window, then compares the latch outputs against the model. It reports mismatches, forbidden-input use and per-command event counts, for use in latch characterisation and self-checking hardware benches.

---
 rtl/sr_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 41 ++++
 rtl/sr_latch_checker.sv | 196 +++++++++++++++++++
 tb/tb_sr_latch_checker.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the NOR SR latch checker.
// Holds the FSM encoding, error codes, command codes and the compare rule.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MODEL = 2'd1;
  localparam logic [1:0] ERR_COMPL = 2'd2;
  localparam logic [1:0] ERR_FORB  = 2'd3;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_RST  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_FORB = 2'b11;

  // Forbidden input must drive both outputs low; otherwise outputs must be
  // complementary, and must match the model only when the model is determinate.
  function automatic logic [1:0] check_code(input logic [1:0] cmd,
                                            input logic       q_v,
                                            input logic       q_bar_v,
                                            input logic       exp_v,
                                            input logic       known_v);
    logic [1:0] code;
    if (cmd == CMD_FORB) begin
      if (q_v || q_bar_v) code = ERR_FORB;
      else                code = ERR_NONE;
    end else if (q_v == q_bar_v) begin
      code = ERR_COMPL;
    end else if (known_v && (q_v != exp_v)) begin
      code = ERR_MODEL;
    end else begin
      code = ERR_NONE;
    end
    return code;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// A synchronous clear takes priority over an increment in the same cycle.
module sat_counter
  import sr_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= {CNT_W{1'b0}};
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/sr_latch_checker.sv
// Watches a NOR SR latch, models its expected state and, after each input
// change has settled, compares the latch outputs against the model.
module sr_latch_checker
  import sr_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_bar,
  output logic             exp_q,
  output logic             exp_known,
  output logic             chk_valid,
  output logic             err,
  output logic             err_sticky,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] set_cnt,
  output logic [CNT_W-1:0] rst_cnt,
  output logic [CNT_W-1:0] forb_cnt
);

  localparam logic [3:0] TIMER_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic [1:0] sr_q, sr_d;
  logic       q_q, q_d;
  logic       q_bar_q, q_bar_d;
  logic       exp_q_q, exp_q_d;
  logic       exp_known_q, exp_known_d;
  logic       chk_valid_q, chk_valid_d;
  logic       err_q, err_d;
  logic       err_sticky_q, err_sticky_d;
  logic [1:0] err_code_q, err_code_d;

  logic [1:0] sr_in_s;
  logic       chg_s;
  logic       do_check_s;
  logic       fire_s;
  logic       fail_s;
  logic [1:0] code_s;
  logic       inc_set_s, inc_rst_s, inc_forb_s;

  // Next-state logic: input sampling, latch model, settle FSM and compare.
  always_comb begin
    sr_in_s      = {s, r};
    chg_s        = (sr_in_s != sr_q);
    sr_d         = sr_in_s;
    q_d          = q;
    q_bar_d      = q_bar;
    exp_q_d      = exp_q_q;
    exp_known_d  = exp_known_q;
    state_d      = state_q;
    timer_d      = timer_q;
    do_check_s   = 1'b0;

    case (sr_in_s)
      CMD_RST: begin
        exp_q_d     = 1'b0;
        exp_known_d = 1'b1;
      end
      CMD_SET: begin
        exp_q_d     = 1'b1;
        exp_known_d = 1'b1;
      end
      CMD_FORB: begin
        exp_q_d     = 1'b0;
        exp_known_d = 1'b1;
      end
      CMD_HOLD: begin
        // Releasing 11 to 00 races the two NOR gates: outcome unknown.
        if (sr_q == CMD_FORB) begin
          exp_q_d     = 1'b0;
          exp_known_d = 1'b0;
        end else begin
          exp_q_d     = exp_q_q;
          exp_known_d = exp_known_q;
        end
      end
      default: begin
        exp_q_d     = exp_q_q;
        exp_known_d = exp_known_q;
      end
    endcase

    case (state_q)
      IDLE: begin
        if (chg_s) begin
          state_d = SETTLE;
          timer_d = TIMER_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (chg_s) begin
          state_d = SETTLE;
          timer_d = TIMER_LOAD;
        end else if (timer_q == 4'd0) begin
          state_d    = CHECK;
          do_check_s = 1'b1;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      CHECK: begin
        if (chg_s) begin
          state_d = SETTLE;
          timer_d = TIMER_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = 4'd0;
      end
    endcase

    code_s      = check_code(sr_q, q_q, q_bar_q, exp_q_q, exp_known_q);
    fire_s      = do_check_s && en;
    fail_s      = fire_s && (code_s != ERR_NONE);
    chk_valid_d = fire_s;
    err_d       = fail_s;
    inc_set_s   = fire_s && (sr_q == CMD_SET);
    inc_rst_s   = fire_s && (sr_q == CMD_RST);
    inc_forb_s  = fire_s && (sr_q == CMD_FORB);

    // A new failure outranks a simultaneous clear for the error record.
    if (fail_s) begin
      err_sticky_d = 1'b1;
      err_code_d   = code_s;
    end else if (clr) begin
      err_sticky_d = 1'b0;
      err_code_d   = err_code_q;
    end else begin
      err_sticky_d = err_sticky_q;
      err_code_d   = err_code_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= 4'd0;
      sr_q         <= CMD_HOLD;
      q_q          <= 1'b0;
      q_bar_q      <= 1'b0;
      exp_q_q      <= 1'b0;
      exp_known_q  <= 1'b0;
      chk_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      sr_q         <= sr_d;
      q_q          <= q_d;
      q_bar_q      <= q_bar_d;
      exp_q_q      <= exp_q_d;
      exp_known_q  <= exp_known_d;
      chk_valid_q  <= chk_valid_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      err_code_q   <= err_code_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_set_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc_set_s), .count(set_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_rst_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc_rst_s), .count(rst_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_forb_cnt (
    .clk(clk), .rst(rst), .clr(clr), .inc(inc_forb_s), .count(forb_cnt)
  );

  assign exp_q      = exp_q_q;
  assign exp_known  = exp_known_q;
  assign chk_valid  = chk_valid_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Self-checking bench for sr_latch_checker: directed scenarios plus random
// traffic, all compared against a rule-level model of the checker.
module tb_sr_latch_checker;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk, rst, en, clr, s, r, q, q_bar;
  logic exp_q, exp_known, chk_valid, err, err_sticky;
  logic [1:0] err_code;
  logic [CNT_W-1:0] set_cnt, rst_cnt, forb_cnt;

  int total = 0;
  int bad   = 0;
  logic [1:0] cur_sr = 2'b00;

  // Reference model state: what the checker should be showing.
  logic [1:0] m_prev_sr, m_qprev, m_code;
  logic       m_exp, m_known, m_chk, m_err, m_sticky, m_pending;
  int         m_age, m_set, m_rst, m_forb;

  logic [30:0] obs;
  assign obs = {exp_q, exp_known, chk_valid, err, err_sticky, err_code, set_cnt, rst_cnt, forb_cnt};

  sr_latch_checker #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s(s), .r(r), .q(q), .q_bar(q_bar),
    .exp_q(exp_q), .exp_known(exp_known), .chk_valid(chk_valid), .err(err),
    .err_sticky(err_sticky), .err_code(err_code),
    .set_cnt(set_cnt), .rst_cnt(rst_cnt), .forb_cnt(forb_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] mvec();
    return {m_exp, m_known, m_chk, m_err, m_sticky, m_code,
            8'(m_set), 8'(m_rst), 8'(m_forb)};
  endfunction

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  // Latch outputs a healthy NOR latch would show for a command.
  function automatic logic [1:0] good_qq(input logic [1:0] sr_v);
    logic [1:0] v;
    logic       b;
    b = 1'($urandom_range(1, 0));
    case (sr_v)
      2'b01:   v = 2'b01;
      2'b10:   v = 2'b10;
      2'b11:   v = 2'b00;
      default: v = m_known ? {m_exp, ~m_exp} : {b, ~b};
    endcase
    return v;
  endfunction

  // Advance the model by one clock edge, given the inputs sampled there.
  task automatic model_edge(input logic [1:0] sr_v, input logic [1:0] qq_v,
                            input logic en_v, input logic clr_v, input logic rst_v);
    logic       fire;
    logic [1:0] code;
    fire = 1'b0;
    code = 2'd0;
    if (rst_v) begin
      m_prev_sr = 2'b00; m_qprev = 2'b00; m_code = 2'd0;
      m_exp = 1'b0; m_known = 1'b0; m_chk = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
      m_pending = 1'b0; m_age = 0; m_set = 0; m_rst = 0; m_forb = 0;
    end else begin
      m_chk = 1'b0;
      m_err = 1'b0;
      if (sr_v != m_prev_sr) begin
        m_pending = 1'b1;
        m_age = 0;
      end else if (m_pending) begin
        m_age++;
        if (m_age == SETTLE) begin
          m_pending = 1'b0;
          fire = en_v;
        end
      end
      if (fire) begin
        m_chk = 1'b1;
        if (sr_v == 2'b11)                          code = (m_qprev != 2'b00) ? 2'd3 : 2'd0;
        else if (m_qprev[1] == m_qprev[0])          code = 2'd2;
        else if (m_known && (m_qprev[1] != m_exp))  code = 2'd1;
        else                                        code = 2'd0;
        m_err = (code != 2'd0);
      end
      if (clr_v) begin
        m_set = 0; m_rst = 0; m_forb = 0;
      end else if (fire) begin
        if (sr_v == 2'b10) m_set  = sat_inc(m_set);
        if (sr_v == 2'b01) m_rst  = sat_inc(m_rst);
        if (sr_v == 2'b11) m_forb = sat_inc(m_forb);
      end
      if (m_err) begin
        m_sticky = 1'b1;
        m_code = code;
      end else if (clr_v) begin
        m_sticky = 1'b0;
      end
      case (sr_v)
        2'b01: begin m_exp = 1'b0; m_known = 1'b1; end
        2'b10: begin m_exp = 1'b1; m_known = 1'b1; end
        2'b11: begin m_exp = 1'b0; m_known = 1'b1; end
        default: if (m_prev_sr == 2'b11) begin m_exp = 1'b0; m_known = 1'b0; end
      endcase
      m_prev_sr = sr_v;
      m_qprev = qq_v;
    end
  endtask

  task automatic drive_cycle(input logic [1:0] sr_v, input logic [1:0] qq_v,
                             input logic en_v, input logic clr_v, input logic rst_v);
    @(negedge clk);
    s = sr_v[1]; r = sr_v[0]; q = qq_v[1]; q_bar = qq_v[0];
    en = en_v; clr = clr_v; rst = rst_v;
    cur_sr = sr_v;
    @(posedge clk);
    model_edge(sr_v, qq_v, en_v, clr_v, rst_v);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      total++;
      if (obs !== 31'd0) begin
        bad++; $display("FAIL reset_zero cyc%0d: got %h want 0", i, obs);
      end
    end
    total++;
    if (obs !== mvec()) begin bad++; $display("FAIL reset_model: got %h want %h", obs, mvec()); end
  endtask

  task automatic test_set_hold();
    int seen;
    int chks;
    seen = -1;
    chks = 0;
    for (int i = 1; i <= 5; i++) begin
      drive_cycle(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== mvec()) begin bad++; $display("FAIL rst_cmd cyc%0d: got %h want %h", i, obs, mvec()); end
      if (chk_valid && seen < 0) seen = i;
    end
    total++;
    if (seen != 3) begin bad++; $display("FAIL chk_latency: got %0d want 3", seen); end
    total++;
    if ({exp_q, exp_known, err_sticky, rst_cnt} !== {1'b0, 1'b1, 1'b0, 8'd1}) begin
      bad++; $display("FAIL rst_cmd_result: got %b %b %b %0d want 0 1 0 1", exp_q, exp_known, err_sticky, rst_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle((i < 4) ? 2'b10 : 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
      if (chk_valid) chks++;
      total++;
      if (obs !== mvec()) begin bad++; $display("FAIL set_hold cyc%0d: got %h want %h", i, obs, mvec()); end
    end
    total++;
    if ({chks, set_cnt, exp_q, err_sticky} !== {32'd2, 8'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL set_hold_result: got chks=%0d set=%0d q=%b sticky=%b want 2 1 1 0", chks, set_cnt, exp_q, err_sticky);
    end
  endtask

  task automatic test_forbidden();
    int errs;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(2'b11, 2'b01, 1'b1, 1'b0, 1'b0);
      if (err) errs++;
      total++;
      if (obs !== mvec()) begin bad++; $display("FAIL forb cyc%0d: got %h want %h", i, obs, mvec()); end
    end
    total++;
    if ({errs, err_code, err_sticky, forb_cnt} !== {32'd1, 2'd3, 1'b1, 8'd1}) begin
      bad++; $display("FAIL forb_result: got errs=%0d code=%0d sticky=%b forb=%0d want 1 3 1 1", errs, err_code, err_sticky, forb_cnt);
    end
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(2'b00, 2'b10, 1'b1, 1'b0, 1'b0);
      if (err) errs++;
      total++;
      if (obs !== mvec()) begin bad++; $display("FAIL race cyc%0d: got %h want %h", i, obs, mvec()); end
    end
    total++;
    if ({errs, exp_known} !== {32'd0, 1'b0}) begin
      bad++; $display("FAIL race_result: got errs=%0d known=%b want 0 0", errs, exp_known);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 4; i++) drive_cycle(2'b01, 2'b10, 1'b1, 1'b0, 1'b0);
    total++;
    if (err_code !== 2'd1) begin bad++; $display("FAIL err_model: got %0d want 1", err_code); end
    for (int i = 0; i < 4; i++) drive_cycle(2'b10, 2'b11, 1'b1, 1'b0, 1'b0);
    total++;
    if (err_code !== 2'd2) begin bad++; $display("FAIL err_compl: got %0d want 2", err_code); end
    drive_cycle(2'b10, 2'b11, 1'b1, 1'b1, 1'b0);
    total++;
    if ({err_sticky, set_cnt, rst_cnt, forb_cnt} !== 25'd0) begin
      bad++; $display("FAIL clr: got sticky=%b %0d %0d %0d want all 0", err_sticky, set_cnt, rst_cnt, forb_cnt);
    end
    // failing compare on the same edge as clr
    for (int i = 0; i <= SETTLE; i++) drive_cycle(2'b01, 2'b10, 1'b1, (i == SETTLE), 1'b0);
    total++;
    if ({err, err_sticky, err_code, rst_cnt} !== {1'b1, 1'b1, 2'd1, 8'd0}) begin
      bad++; $display("FAIL clr_collide: got err=%b sticky=%b code=%0d rst=%0d want 1 1 1 0", err, err_sticky, err_code, rst_cnt);
    end
    total++;
    if (obs !== mvec()) begin bad++; $display("FAIL errors_model: got %h want %h", obs, mvec()); end
  endtask

  task automatic test_back_to_back();
    int chks;
    chks = 0;
    for (int i = 0; i < 5 + SETTLE + 3; i++) begin
      logic [1:0] v;
      v = (i < 5) ? ((i % 2 == 0) ? 2'b10 : 2'b01) : 2'b10;
      drive_cycle(v, good_qq(v), 1'b1, 1'b0, 1'b0);
      if (chk_valid) chks++;
      total++;
      if (obs !== mvec()) begin bad++; $display("FAIL toggle cyc%0d: got %h want %h", i, obs, mvec()); end
    end
    total++;
    if (chks != 1) begin bad++; $display("FAIL toggle_count: got %0d want 1", chks); end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 600; n++) begin
      logic [1:0] v;
      v = (n % 2 == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k <= SETTLE; k++) drive_cycle(v, good_qq(v), 1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== mvec()) begin bad++; $display("FAIL sat n%0d: got %h want %h", n, obs, mvec()); end
    end
    total++;
    if ({set_cnt, rst_cnt} !== {8'd255, 8'd255}) begin
      bad++; $display("FAIL sat_value: got %0d %0d want 255 255", set_cnt, rst_cnt);
    end
  endtask

  task automatic test_rst_mid();
    int chks;
    chks = 0;
    drive_cycle(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    if (chk_valid) chks++;
    drive_cycle(2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
    if (chk_valid) chks++;
    total++;
    if (obs !== 31'd0) begin bad++; $display("FAIL rst_mid_zero: got %h want 0", obs); end
    total++;
    if (chks != 0) begin bad++; $display("FAIL rst_mid_pulse: got %0d want 0", chks); end
    for (int i = 0; i < 5; i++) begin
      drive_cycle(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== mvec()) begin bad++; $display("FAIL rst_mid_after cyc%0d: got %h want %h", i, obs, mvec()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] v, qq;
      v  = ($urandom_range(2, 0) == 0) ? 2'($urandom) : cur_sr;
      qq = ($urandom_range(9, 0) < 8) ? good_qq(v) : 2'($urandom);
      drive_cycle(v, qq, ($urandom_range(9, 0) != 0), ($urandom_range(39, 0) == 0),
                  ($urandom_range(199, 0) == 0));
      total++;
      if (obs !== mvec()) begin bad++; $display("FAIL random cyc%0d: got %h want %h", i, obs, mvec()); end
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; en = 1'b0; clr = 1'b0;
    s = 1'b0; r = 1'b0; q = 1'b0; q_bar = 1'b0;
    model_edge(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_set_hold();
    test_forbidden();
    test_errors();
    test_back_to_back();
    test_saturation();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
